// File: rtl/adc_pkt_capture.sv
// adc_pkt_capture: ADC sample capture endpoint.
// Groups incoming signed samples into fixed-length packets, buffers them in a
// FIFO and replays them on a sign-extended valid/ready stream with tlast.
module adc_pkt_capture #(
  parameter int ADC_WIDTH  = 14,
  parameter int OUT_WIDTH  = 16,
  parameter int PKT_LEN    = 500,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  num_pkts,
  input  logic signed [ADC_WIDTH-1:0] adc_data,
  input  logic                        adc_valid,
  output logic signed [OUT_WIDTH-1:0] m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [7:0]                  pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [AW:0]   DEPTH_P  = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADC_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [AW:0]        occupancy;
  logic               fifo_empty, fifo_full;
  logic [IW-1:0]      samp_idx;
  logic [7:0]         num_lat;
  logic               wr_last;
  logic               wr_en, rd_en, start_acc, ovf_evt, done_next;
  logic [ADC_WIDTH:0] rd_word_p0;

  // Widen a two's complement ADC sample to the output width.
  function automatic logic signed [OUT_WIDTH-1:0] sign_ext(
    input logic signed [ADC_WIDTH-1:0] d
  );
    return OUT_WIDTH'(d);
  endfunction

  // The sample held in the output register still counts as occupied, so a
  // stalled consumer sees at most FIFO_DEPTH buffered samples in total.
  assign occupancy  = (wr_ptr - rd_ptr) + (AW+1)'(m_tvalid);
  assign fifo_full  = (occupancy == DEPTH_P);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign wr_last    = (samp_idx == LAST_IDX);
  assign rd_en      = !fifo_empty && (!m_tvalid || m_tready);
  assign rd_word_p0 = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    wr_en      = 1'b0;
    ovf_evt    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (num_pkts != 8'd0)) begin
          start_acc  = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          if (fifo_full) begin
            // Sample is dropped; whatever is buffered is still delivered.
            ovf_evt    = 1'b1;
            state_next = DRAIN;
          end else begin
            wr_en = 1'b1;
            if (wr_last && ((pkt_count + 8'd1) == num_lat)) state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave as the final beat transfers so done lands in the next cycle.
        if (fifo_empty && (!m_tvalid || m_tready)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: packet target, sample index, packet count, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat   <= 8'd0;
      samp_idx  <= '0;
      pkt_count <= 8'd0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (start_acc) begin
        num_lat   <= num_pkts;
        samp_idx  <= '0;
        pkt_count <= 8'd0;
        overflow  <= 1'b0;
      end else begin
        if (wr_en) begin
          samp_idx <= wr_last ? '0 : samp_idx + 1'b1;
          if (wr_last) pkt_count <= pkt_count + 8'd1;
        end
        if (ovf_evt) overflow <= 1'b1;
      end
    end
  end

  // FIFO storage: {last, sample}; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, adc_data};
  end

  // FIFO pointers; the extra MSB distinguishes full from empty on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr <= rd_ptr + (AW+1)'(rd_en);
    end
  end

  // Output register: loads when empty or when the held beat transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (rd_en) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sign_ext($signed(rd_word_p0[ADC_WIDTH-1:0]));
      m_tlast  <= rd_word_p0[ADC_WIDTH];
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_pkt_capture.sv
// Testbench for adc_pkt_capture: randomized runs against a packet-level
// reference model, with a scoreboard queue drained by an output monitor.
module tb_adc_pkt_capture;

  localparam int ADC_W   = 14;
  localparam int OUT_W   = 16;
  localparam int PLEN    = 500;
  localparam int DEPTH   = 1024;
  localparam real PI     = 3.14159265358979;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        num_pkts = 8'd0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              busy, done, overflow;
  logic [7:0]        pkt_count;

  adc_pkt_capture #(
    .ADC_WIDTH(ADC_W), .OUT_WIDTH(OUT_W), .PKT_LEN(PLEN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pkts(num_pkts),
    .adc_data(adc_data), .adc_valid(adc_valid), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .overflow(overflow), .pkt_count(pkt_count)
  );

  always #4 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: expected {last, data} beats in delivery order.
  logic [OUT_W:0] sb_q[$];
  logic [ADC_W-1:0] force_q[$];

  // Reference model of the current run.
  int  pushes = 0;
  int  xfers = 0;
  int  done_cnt = 0;
  int  mcyc = 0;
  int  last_xfer_cyc = -10;
  int  tone_n = 0;
  bit  m_cap = 0;
  int  m_idx = 0;
  int  m_pkts = 0;
  int  m_target = 0;
  bit  m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] sext(input logic [ADC_W-1:0] d);
    int v;
    v = int'(d);
    if (v >= (1 << (ADC_W - 1))) v = v - (1 << ADC_W);
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [ADC_W-1:0] gen_sample(input int vm);
    int v;
    if (force_q.size() != 0) return force_q.pop_front();
    if (vm == 0) begin
      v = $rtoi(7000.0 * $sin(2.0 * PI * 37.21 / 125.0 * real'(tone_n)));
      tone_n++;
      return v[ADC_W-1:0];
    end
    v = int'($urandom);
    return v[ADC_W-1:0];
  endfunction

  function automatic logic ready_for(input int rm, input int c, input int occ, input bit cap);
    case (rm)
      0: return 1'b1;
      1: return !cap;
      2: return ((c / 3) % 2) == 0;
      3: return !cap || (occ == DEPTH);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every transfer, checks stalls and done.
  initial begin : monitor
    bit prev_stall;
    logic [OUT_W:0] prev_beat;
    logic [OUT_W:0] exp;
    prev_stall = 0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("tvalid_hold", {31'd0, m_tvalid}, 32'd1);
        chk("beat_hold", {15'd0, m_tlast, m_tdata}, {15'd0, prev_beat});
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", mcyc, last_xfer_cyc + 1);
        chk("sb_empty_at_done", sb_q.size(), 0);
      end
      if (m_tvalid && m_tready) begin
        xfers++;
        last_xfer_cyc = mcyc;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got 0x%0h, none expected", {m_tlast, m_tdata});
        end else begin
          exp = sb_q.pop_front();
          chk("beat", {15'd0, m_tlast, m_tdata}, {15'd0, exp});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  // One capture run: start, feed samples while the model captures, then drain.
  task automatic run_capture(input int n, input int vm, input int rm, input int late_n);
    int c, occ, d0, budget;
    bit last;
    logic [ADC_W-1:0] s;
    c = 0;
    d0 = done_cnt;
    start = 1'b1;
    num_pkts = n[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, (n != 0) ? 32'd1 : 32'd0);
    if (n == 0) return;
    m_cap = 1; m_idx = 0; m_pkts = 0; m_target = n; m_ovf = 0;
    while (m_cap && c < 20000) begin
      occ = pushes - xfers;
      m_tready = ready_for(rm, c, occ, 1'b1);
      adc_valid = (vm == 0) ? 1'b1 : (vm == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      start = (late_n != 0) && (c == 50);
      num_pkts = start ? late_n[7:0] : n[7:0];
      if (adc_valid) begin
        s = gen_sample(vm);
        adc_data = s;
        if (occ >= DEPTH) begin
          m_ovf = 1;
          m_cap = 0;
        end else begin
          last = (m_idx == PLEN - 1);
          sb_q.push_back({last, sext(s)});
          pushes++;
          m_idx = last ? 0 : m_idx + 1;
          if (last) begin
            m_pkts++;
            if (m_pkts == m_target) m_cap = 0;
          end
        end
      end else begin
        adc_data = ADC_W'($urandom);
      end
      @(posedge clk); #1;
      c++;
    end
    adc_valid = 1'b0;
    start = 1'b0;
    chk("capture_bounded", {31'd0, m_cap}, 32'd0);
    budget = 0;
    while (done_cnt == d0 && budget < 5000) begin
      m_tready = ready_for(rm, c, pushes - xfers, 1'b0);
      adc_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      c++;
      budget++;
    end
    adc_valid = 1'b0;
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("pkt_count", {24'd0, pkt_count}, m_pkts);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin : stim
    int d0;
    // Reset state.
    #3;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
    chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // num_pkts = 0 is ignored.
    run_capture(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("busy_zero_pkts", {31'd0, busy}, 32'd0);

    // Sign extension corners at the head of a random-gapped run.
    force_q.push_back(14'h2000);
    force_q.push_back(14'h1FFF);
    force_q.push_back(14'h3FFF);
    force_q.push_back(14'h0000);
    run_capture(1, 2, 0, 0);

    // Continuous tone capture, 10 packets.
    run_capture(10, 0, 0, 0);

    // Overflow with a stalled consumer.
    run_capture(3, 0, 1, 0);
    chk("ovf_pushes", pushes, 32'd1024 + 32'd500 + 32'd5000);
    repeat (3) @(posedge clk);
    #1;
    chk("overflow_held", {31'd0, overflow}, 32'd1);
    chk("pkt_count_held", {24'd0, pkt_count}, 32'd2);

    // Gapped input with periodic backpressure.
    run_capture(1, 1, 2, 0);

    // start during CAPTURE is ignored.
    run_capture(2, 0, 0, 7);

    // Full FIFO while a pop happens in the same cycle.
    run_capture(3, 0, 3, 0);

    // Reset in the middle of a run.
    d0 = done_cnt;
    start = 1'b1;
    num_pkts = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    m_tready = 1'b0;
    adc_valid = 1'b1;
    repeat (200) begin
      adc_data = ADC_W'($urandom);
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_pkt_count", {24'd0, pkt_count}, 32'd0);
    chk("midrst_tdata", {15'd0, m_tlast, m_tdata}, 32'd0);
    sb_q.delete();
    pushes = 0;
    xfers = 0;
    m_cap = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    chk("midrst_no_beats", {31'd0, m_tvalid}, 32'd0);

    // Clean run after reset with random backpressure.
    run_capture(1, 2, 4, 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
